// File: rtl/hour24_timer_if.sv
// Signal bundle between the hour stage and its surroundings (minute stage,
// time-zone/mode config, set controls, display and date logic).
interface hour24_timer_if;
  logic       min_cycle;
  logic [4:0] tz_offset;
  logic       mode12;
  logic       set_en;
  logic       set_btn;
  logic [4:0] base_hr;
  logic [4:0] disp_hr;
  logic [3:0] hr_tens;
  logic [3:0] hr_ones;
  logic       pm;
  logic [1:0] day_rel;
  logic       day_carry;

  modport slave (
    input  min_cycle, tz_offset, mode12, set_en, set_btn,
    output base_hr, disp_hr, hr_tens, hr_ones, pm, day_rel, day_carry
  );

  modport master (
    output min_cycle, tz_offset, mode12, set_en, set_btn,
    input  base_hr, disp_hr, hr_tens, hr_ones, pm, day_rel, day_carry
  );
endinterface

// File: rtl/hour24_timer.sv
// Hour stage of the world clock: base hour counter with RUN/SET modes,
// button-driven manual set, time-zone offset and registered 24h/12h BCD display.
module hour24_timer (
  input  logic           clk,
  input  logic           reset_n,
  hour24_timer_if.slave  bus
);

  typedef enum logic {RUN, SET} state_e;

  state_e     state_q, state_d;
  logic [4:0] base_q, base_d;
  logic       carry_q, carry_d;
  logic       s1_q, s2_q, s3_q;
  logic       rise;

  logic [4:0] disp_q, disp_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       pm_q, pm_d;
  logic [1:0] rel_q, rel_d;

  logic signed [4:0] tz_s;
  logic signed [4:0] eff;
  logic              tz_ok;
  logic signed [6:0] sum;
  logic [4:0]        loc_hr;

  // Button: two-flop synchronizer plus an edge-detect flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= bus.set_btn;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      base_q  <= 5'd0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      carry_q <= carry_d;
    end
  end

  // The counting action uses the current state, so the edge that switches
  // state still applies the old state's increment source.
  always_comb begin
    state_d = bus.set_en ? SET : RUN;
    base_d  = base_q;
    carry_d = 1'b0;
    case (state_q)
      RUN: begin
        if (bus.min_cycle) begin
          if (base_q == 5'd23) begin
            base_d  = 5'd0;
            carry_d = 1'b1;
          end else begin
            base_d = base_q + 5'd1;
          end
        end
      end
      SET: begin
        if (rise) base_d = (base_q == 5'd23) ? 5'd0 : base_q + 5'd1;
      end
      default: base_d = base_q;
    endcase
  end

  // Offsets outside -12..+14 are treated as zero.
  assign tz_s  = bus.tz_offset;
  assign tz_ok = (tz_s >= -5'sd12) && (tz_s <= 5'sd14);
  assign eff   = tz_ok ? tz_s : 5'sd0;

  // 7 bits so that 23 + 14 = 37 stays positive.
  assign sum = $signed({2'b00, base_q}) + $signed({{2{eff[4]}}, eff});

  always_comb begin
    rel_d  = 2'b00;
    loc_hr = sum[4:0];
    if (sum < 7'sd0) begin
      loc_hr = 5'(sum + 7'sd24);
      rel_d  = 2'b11;
    end else if (sum > 7'sd23) begin
      loc_hr = 5'(sum - 7'sd24);
      rel_d  = 2'b01;
    end
  end

  always_comb begin
    pm_d   = (loc_hr >= 5'd12);
    disp_d = loc_hr;
    if (bus.mode12) begin
      if (loc_hr == 5'd0)      disp_d = 5'd12;
      else if (loc_hr > 5'd12) disp_d = loc_hr - 5'd12;
    end
  end

  always_comb begin
    tens_d = 4'd0;
    ones_d = 4'(disp_d);
    if (disp_d >= 5'd20) begin
      tens_d = 4'd2;
      ones_d = 4'(disp_d - 5'd20);
    end else if (disp_d >= 5'd10) begin
      tens_d = 4'd1;
      ones_d = 4'(disp_d - 5'd10);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      disp_q <= 5'd0;
      tens_q <= 4'd0;
      ones_q <= 4'd0;
      pm_q   <= 1'b0;
      rel_q  <= 2'b00;
    end else begin
      disp_q <= disp_d;
      tens_q <= tens_d;
      ones_q <= ones_d;
      pm_q   <= pm_d;
      rel_q  <= rel_d;
    end
  end

  assign bus.base_hr   = base_q;
  assign bus.day_carry = carry_q;
  assign bus.disp_hr   = disp_q;
  assign bus.hr_tens   = tens_q;
  assign bus.hr_ones   = ones_q;
  assign bus.pm        = pm_q;
  assign bus.day_rel   = rel_q;

endmodule

// File: tb/tb_hour24_timer.sv
// Self-checking bench for hour24_timer: directed scenarios plus a randomized
// run against an arithmetic reference model of the hour/offset/display rules.
module tb_hour24_timer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hour24_timer_if bus();

  hour24_timer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  function automatic int eff_off(logic [4:0] tz);
    int v;
    v = int'($signed(tz));
    return (v < -12 || v > 14) ? 0 : v;
  endfunction

  function automatic int loc_of(int b, logic [4:0] tz);
    return (b + eff_off(tz) + 24) % 24;
  endfunction

  function automatic int rel_of(int b, logic [4:0] tz);
    int s;
    s = b + eff_off(tz);
    return (s < 0) ? 3 : (s > 23) ? 1 : 0;
  endfunction

  function automatic int disp_of(int l, bit m12);
    if (!m12) return l;
    return (l % 12 == 0) ? 12 : l % 12;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    bus.min_cycle = 1'b0;
    bus.tz_offset = 5'd0;
    bus.mode12    = 1'b0;
    bus.set_en    = 1'b0;
    bus.set_btn   = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
  endtask

  task automatic set_base(input int n);
    do_reset();
    bus.min_cycle = 1'b1;
    repeat (n) step();
    bus.min_cycle = 1'b0;
  endtask

  task automatic test_reset();
    set_base(9);
    step();
    reset_n = 1'b0;
    #1;
    checks++; if (bus.base_hr !== 5'd0)   begin errors++; $display("FAIL rst_base got %0d exp 0", bus.base_hr); end
    checks++; if (bus.disp_hr !== 5'd0)   begin errors++; $display("FAIL rst_disp got %0d exp 0", bus.disp_hr); end
    checks++; if (bus.hr_tens !== 4'd0)   begin errors++; $display("FAIL rst_tens got %0d exp 0", bus.hr_tens); end
    checks++; if (bus.hr_ones !== 4'd0)   begin errors++; $display("FAIL rst_ones got %0d exp 0", bus.hr_ones); end
    checks++; if (bus.pm !== 1'b0)        begin errors++; $display("FAIL rst_pm got %0b exp 0", bus.pm); end
    checks++; if (bus.day_rel !== 2'b00)  begin errors++; $display("FAIL rst_rel got %0b exp 00", bus.day_rel); end
    checks++; if (bus.day_carry !== 1'b0) begin errors++; $display("FAIL rst_carry got %0b exp 0", bus.day_carry); end
    do_reset();
  endtask

  task automatic test_rollover();
    do_reset();
    bus.min_cycle = 1'b1;
    for (int i = 0; i < 23; i++) begin
      step();
      checks++;
      if (bus.day_carry !== 1'b0) begin errors++; $display("FAIL roll_nocarry pulse %0d got %0b exp 0", i + 1, bus.day_carry); end
    end
    checks++; if (bus.base_hr !== 5'd23) begin errors++; $display("FAIL roll_23 got %0d exp 23", bus.base_hr); end
    step();
    bus.min_cycle = 1'b0;
    checks++; if (bus.base_hr !== 5'd0)   begin errors++; $display("FAIL roll_wrap got %0d exp 0", bus.base_hr); end
    checks++; if (bus.day_carry !== 1'b1) begin errors++; $display("FAIL roll_carry got %0b exp 1", bus.day_carry); end
    checks++; if (bus.disp_hr !== 5'd23)  begin errors++; $display("FAIL roll_lag got %0d exp 23", bus.disp_hr); end
    step();
    checks++; if (bus.day_carry !== 1'b0) begin errors++; $display("FAIL roll_carry_1cyc got %0b exp 0", bus.day_carry); end
    checks++; if (bus.disp_hr !== 5'd0)   begin errors++; $display("FAIL roll_disp0 got %0d exp 0", bus.disp_hr); end
  endtask

  task automatic test_tz();
    set_base(2);
    bus.tz_offset = 5'b11011; // -5
    step();
    checks++; if (bus.disp_hr !== 5'd21) begin errors++; $display("FAIL tz_m5_disp got %0d exp 21", bus.disp_hr); end
    checks++; if (bus.day_rel !== 2'b11) begin errors++; $display("FAIL tz_m5_rel got %0b exp 11", bus.day_rel); end
    checks++; if (bus.hr_tens !== 4'd2 || bus.hr_ones !== 4'd1)
      begin errors++; $display("FAIL tz_m5_bcd got %0d%0d exp 21", bus.hr_tens, bus.hr_ones); end
    set_base(20);
    bus.tz_offset = 5'd14;
    step();
    checks++; if (bus.disp_hr !== 5'd10) begin errors++; $display("FAIL tz_p14_disp got %0d exp 10", bus.disp_hr); end
    checks++; if (bus.day_rel !== 2'b01) begin errors++; $display("FAIL tz_p14_rel got %0b exp 01", bus.day_rel); end
    bus.tz_offset = 5'b10011; // -13, out of range
    step();
    checks++; if (bus.disp_hr !== 5'd20) begin errors++; $display("FAIL tz_m13_disp got %0d exp 20", bus.disp_hr); end
    checks++; if (bus.day_rel !== 2'b00) begin errors++; $display("FAIL tz_m13_rel got %0b exp 00", bus.day_rel); end
  endtask

  task automatic test_mode12();
    int locs [5] = '{0, 11, 12, 13, 23};
    int edisp[5] = '{12, 11, 12, 1, 11};
    int epm  [5] = '{0, 0, 1, 1, 1};
    int eten [5] = '{1, 1, 1, 0, 1};
    int eone [5] = '{2, 1, 2, 1, 1};
    for (int i = 0; i < 5; i++) begin
      set_base(locs[i]);
      bus.mode12 = 1'b1;
      step();
      checks++; if (bus.disp_hr !== 5'(edisp[i])) begin errors++; $display("FAIL m12_disp loc %0d got %0d exp %0d", locs[i], bus.disp_hr, edisp[i]); end
      checks++; if (bus.pm !== 1'(epm[i]))         begin errors++; $display("FAIL m12_pm loc %0d got %0b exp %0d", locs[i], bus.pm, epm[i]); end
      checks++; if (bus.hr_tens !== 4'(eten[i]) || bus.hr_ones !== 4'(eone[i]))
        begin errors++; $display("FAIL m12_bcd loc %0d got %0d,%0d exp %0d,%0d", locs[i], bus.hr_tens, bus.hr_ones, eten[i], eone[i]); end
    end
  endtask

  task automatic test_set_button();
    bit carry_seen;
    set_base(5);
    bus.set_en = 1'b1;
    step();
    bus.set_btn = 1'b1;
    step();
    checks++; if (bus.base_hr !== 5'd5) begin errors++; $display("FAIL set_e1 got %0d exp 5", bus.base_hr); end
    step();
    checks++; if (bus.base_hr !== 5'd5) begin errors++; $display("FAIL set_e2 got %0d exp 5", bus.base_hr); end
    step();
    checks++; if (bus.base_hr !== 5'd6) begin errors++; $display("FAIL set_e3 got %0d exp 6", bus.base_hr); end
    checks++; if (bus.disp_hr !== 5'd5) begin errors++; $display("FAIL set_e3_disp got %0d exp 5", bus.disp_hr); end
    step();
    checks++; if (bus.disp_hr !== 5'd6) begin errors++; $display("FAIL set_e4_disp got %0d exp 6", bus.disp_hr); end
    repeat (6) step();
    checks++; if (bus.base_hr !== 5'd6) begin errors++; $display("FAIL set_held got %0d exp 6", bus.base_hr); end
    bus.set_btn   = 1'b0;
    bus.min_cycle = 1'b1;
    repeat (3) step();
    bus.min_cycle = 1'b0;
    checks++; if (bus.base_hr !== 5'd6) begin errors++; $display("FAIL set_ignore_min got %0d exp 6", bus.base_hr); end

    set_base(23);
    bus.set_en = 1'b1;
    step();
    bus.set_btn = 1'b1;
    carry_seen  = 1'b0;
    repeat (4) begin
      step();
      if (bus.day_carry) carry_seen = 1'b1;
    end
    bus.set_btn = 1'b0;
    checks++; if (bus.base_hr !== 5'd0) begin errors++; $display("FAIL set_wrap got %0d exp 0", bus.base_hr); end
    checks++; if (carry_seen !== 1'b0)  begin errors++; $display("FAIL set_wrap_carry got %0b exp 0", carry_seen); end
    bus.set_en = 1'b0;
  endtask

  task automatic test_back_to_back();
    set_base(4);
    bus.set_en    = 1'b1;
    bus.min_cycle = 1'b1;
    step();
    checks++; if (bus.base_hr !== 5'd5) begin errors++; $display("FAIL b2b_enter got %0d exp 5", bus.base_hr); end
    step();
    bus.min_cycle = 1'b0;
    checks++; if (bus.base_hr !== 5'd5) begin errors++; $display("FAIL b2b_inset got %0d exp 5", bus.base_hr); end
    bus.set_btn = 1'b1;
    repeat (2) step();
    bus.set_en = 1'b0;
    step();
    checks++; if (bus.base_hr !== 5'd6) begin errors++; $display("FAIL b2b_exit_rise got %0d exp 6", bus.base_hr); end
    bus.min_cycle = 1'b1;
    step();
    bus.min_cycle = 1'b0;
    bus.set_btn   = 1'b0;
    checks++; if (bus.base_hr !== 5'd7) begin errors++; $display("FAIL b2b_run_again got %0d exp 7", bus.base_hr); end
  endtask

  task automatic test_async_reset();
    set_base(7);
    bus.set_en = 1'b1;
    step();
    bus.set_btn = 1'b1;
    step();
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (bus.base_hr !== 5'd0 || bus.disp_hr !== 5'd0 || bus.hr_ones !== 4'd0 || bus.pm !== 1'b0 || bus.day_rel !== 2'b00)
      begin errors++; $display("FAIL arst_outputs got base %0d disp %0d ones %0d", bus.base_hr, bus.disp_hr, bus.hr_ones); end
    bus.set_en = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (5) step();
    bus.set_btn = 1'b0;
    checks++; if (bus.base_hr !== 5'd0) begin errors++; $display("FAIL arst_no_inc got %0d exp 0", bus.base_hr); end
    checks++; if (bus.disp_hr !== 5'd0) begin errors++; $display("FAIL arst_disp got %0d exp 0", bus.disp_hr); end
  endtask

  task automatic test_random();
    int m_base, e_loc, e_disp, e_rel;
    bit mc, m12, e_pm, e_carry;
    logic [4:0] tz;
    do_reset();
    m_base = 0;
    for (int c = 0; c < 10000; c++) begin
      mc  = 1'($urandom_range(0, 1));
      m12 = 1'($urandom_range(0, 1));
      tz  = 5'($urandom);
      bus.min_cycle = mc;
      bus.mode12    = m12;
      bus.tz_offset = tz;
      e_loc   = loc_of(m_base, tz);
      e_disp  = disp_of(e_loc, m12);
      e_pm    = (e_loc >= 12);
      e_rel   = rel_of(m_base, tz);
      e_carry = mc && (m_base == 23);
      if (mc) m_base = (m_base + 1) % 24;
      step();
      checks++; if (bus.base_hr !== 5'(m_base))        begin errors++; $display("FAIL rnd_base cyc %0d got %0d exp %0d", c, bus.base_hr, m_base); end
      checks++; if (bus.day_carry !== e_carry)         begin errors++; $display("FAIL rnd_carry cyc %0d got %0b exp %0b", c, bus.day_carry, e_carry); end
      checks++; if (bus.disp_hr !== 5'(e_disp))        begin errors++; $display("FAIL rnd_disp cyc %0d got %0d exp %0d", c, bus.disp_hr, e_disp); end
      checks++; if (bus.hr_tens !== 4'(e_disp / 10))   begin errors++; $display("FAIL rnd_tens cyc %0d got %0d exp %0d", c, bus.hr_tens, e_disp / 10); end
      checks++; if (bus.hr_ones !== 4'(e_disp % 10))   begin errors++; $display("FAIL rnd_ones cyc %0d got %0d exp %0d", c, bus.hr_ones, e_disp % 10); end
      checks++; if (bus.pm !== e_pm)                   begin errors++; $display("FAIL rnd_pm cyc %0d got %0b exp %0b", c, bus.pm, e_pm); end
      checks++; if (bus.day_rel !== 2'(e_rel))         begin errors++; $display("FAIL rnd_rel cyc %0d got %0d exp %0d", c, bus.day_rel, e_rel); end
    end
    bus.min_cycle = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_tz();
    test_mode12();
    test_set_button();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
